// File: rtl/grf_wb_pkg.sv
// Shared constants for the P5 writeback stage and register file.
package grf_wb_pkg;

    localparam int GRF_NREG = 32;
    localparam int GRF_DW   = 32;
    localparam int GRF_AW   = 5;

    // Mem2Reg writeback source encodings; 3 is reserved and falls back to AO
    localparam logic [1:0] M2R_AO   = 2'd0;
    localparam logic [1:0] M2R_DM   = 2'd1;
    localparam logic [1:0] M2R_LINK = 2'd2;

    localparam logic [GRF_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [GRF_AW-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/grf_wb_mux.sv
// Writeback source select: ALU result, DM read data or PC+8 link address.
module grf_wb_mux
    import grf_wb_pkg::*;
#(
    parameter int DW = GRF_DW
) (
    input  logic [1:0]    Mem2Reg,
    input  logic [DW-1:0] AO_W,
    input  logic [DW-1:0] DR_W,
    input  logic [DW-1:0] PC8_W,
    output logic [DW-1:0] WD
);

    always_comb begin
        WD = AO_W;
        case (Mem2Reg)
            M2R_AO:   WD = AO_W;
            M2R_DM:   WD = DR_W;
            M2R_LINK: WD = PC8_W;
            default:  WD = AO_W;
        endcase
    end

endmodule

// File: rtl/grf_wb.sv
// 32x32 general register file with W-stage writeback select, W->D bypass
// and a registered one-cycle writeback trace record.
module grf_wb
    import grf_wb_pkg::*;
#(
    parameter int NREG = GRF_NREG,
    parameter int DW   = GRF_DW,
    parameter int AW   = GRF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    Mem2Reg,
    input  logic          RegWE,
    input  logic [AW-1:0] A3,
    input  logic [DW-1:0] AO_W,
    input  logic [DW-1:0] DR_W,
    input  logic [DW-1:0] PC8_W,
    input  logic [AW-1:0] A1,
    input  logic [AW-1:0] A2,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    output logic [DW-1:0] WD,
    output logic          trace_valid,
    output logic [AW-1:0] trace_addr,
    output logic [DW-1:0] trace_data
);

    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [DW-1:0] regs [0:NREG-1];
    logic          wr;

    grf_wb_mux #(.DW(DW)) u_mux (
        .Mem2Reg (Mem2Reg),
        .AO_W    (AO_W),
        .DR_W    (DR_W),
        .PC8_W   (PC8_W),
        .WD      (WD)
    );

    // Reset gates the commit so a write presented while reset is low is lost
    // and never reaches the bypass either.
    assign wr = RegWE & (A3 != ZERO) & reset;

    always_comb begin
        RD1 = regs[A1];
        if (A1 == ZERO)
            RD1 = '0;
        else if (wr && (A3 == A1))
            RD1 = WD;
    end

    always_comb begin
        RD2 = regs[A2];
        if (A2 == ZERO)
            RD2 = '0;
        else if (wr && (A3 == A2))
            RD2 = WD;
    end

    // Trace is a pulse with no back-pressure: trace_valid marks one committed
    // write; addr/data update every edge and are meaningful only when valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            trace_valid <= 1'b0;
            trace_addr  <= '0;
            trace_data  <= '0;
        end else begin
            if (wr)
                regs[A3] <= WD;
            trace_valid <= wr;
            trace_addr  <= A3;
            trace_data  <= WD;
        end
    end

endmodule

// File: tb/tb_grf_wb.sv
// Directed table-driven bench for grf_wb plus hand sequences for async reset.
module tb_grf_wb;

    logic        clk;
    logic        reset;
    logic [1:0]  Mem2Reg;
    logic        RegWE;
    logic [4:0]  A3;
    logic [31:0] AO_W;
    logic [31:0] DR_W;
    logic [31:0] PC8_W;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] WD;
    logic        trace_valid;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    grf_wb dut (
        .clk         (clk),
        .reset       (reset),
        .Mem2Reg     (Mem2Reg),
        .RegWE       (RegWE),
        .A3          (A3),
        .AO_W        (AO_W),
        .DR_W        (DR_W),
        .PC8_W       (PC8_W),
        .A1          (A1),
        .A2          (A2),
        .RD1         (RD1),
        .RD2         (RD2),
        .WD          (WD),
        .trace_valid (trace_valid),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  m2r;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] ao;
        logic [31:0] dr;
        logic [31:0] pc8;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic        exp_commit;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m2r, input logic we, input logic [4:0] a3,
                         input logic [31:0] ao, input logic [31:0] dr, input logic [31:0] pc8,
                         input logic [4:0] a1, input logic [4:0] a2);
        Mem2Reg = m2r;
        RegWE   = we;
        A3      = a3;
        AO_W    = ao;
        DR_W    = dr;
        PC8_W   = pc8;
        A1      = a1;
        A2      = a2;
    endtask

    // trace scoreboard: expected data pushed when a vector is driven, popped after its edge
    task automatic check_trace(input string tag, input logic exp_valid, input logic [4:0] exp_addr);
        logic [31:0] exp_data;
        check({tag, "_trace_valid"}, {31'd0, trace_valid}, {31'd0, exp_valid});
        check({tag, "_trace_addr"}, {27'd0, trace_addr}, {27'd0, exp_addr});
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_trace_q: got empty queue expected one entry", tag);
        end else begin
            exp_data = exp_q.pop_front();
            check({tag, "_trace_data"}, trace_data, exp_data);
        end
    endtask

    initial begin
        //        m2r  we a3  ao            dr            pc8           a1  a2  wd            rd1           rd2           commit
        vecs[0]  = '{2'd0, 0, 0,  32'h0,        32'h0,        32'h0,        5,  31, 32'h0,        32'h0,        32'h0,        0};
        vecs[1]  = '{2'd0, 1, 8,  32'h0000_1234, 32'h0,       32'h0,        8,  0,  32'h0000_1234, 32'h0000_1234, 32'h0,      1};
        vecs[2]  = '{2'd0, 0, 8,  32'h0,        32'h0,        32'h0,        8,  9,  32'h0,        32'h0000_1234, 32'h0,       0};
        vecs[3]  = '{2'd1, 1, 9,  32'h11,       32'hDEAD_BEEF, 32'h0,       9,  8,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_1234, 1};
        vecs[4]  = '{2'd2, 1, 31, 32'h22,       32'h33,       32'h0000_3008, 9, 31, 32'h0000_3008, 32'hDEAD_BEEF, 32'h0000_3008, 1};
        vecs[5]  = '{2'd0, 1, 0,  32'hFFFF_FFFF, 32'h0,       32'h0,        0,  31, 32'hFFFF_FFFF, 32'h0,        32'h0000_3008, 0};
        vecs[6]  = '{2'd0, 0, 10, 32'h55,       32'h0,        32'h0,        10, 9,  32'h55,       32'h0,        32'hDEAD_BEEF, 0};
        vecs[7]  = '{2'd3, 1, 12, 32'hAAAA,     32'hBBBB,     32'hCCCC,     12, 12, 32'hAAAA,     32'hAAAA,     32'hAAAA,     1};
        vecs[8]  = '{2'd1, 1, 8,  32'h1,        32'h5678,     32'h2,        8,  12, 32'h5678,     32'h5678,     32'hAAAA,     1};
        vecs[9]  = '{2'd0, 0, 0,  32'h0,        32'h0,        32'h0,        8,  31, 32'h0,        32'h5678,     32'h0000_3008, 0};
        vecs[10] = '{2'd2, 0, 31, 32'h0,        32'h0,        32'h9999,     31, 10, 32'h9999,     32'h0000_3008, 32'h0,       0};

        reset = 1'b0;
        drive(2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
        repeat (3) @(posedge clk);
        #1;
        check("rst_trace_valid", {31'd0, trace_valid}, 32'h0);
        check("rst_trace_addr", {27'd0, trace_addr}, 32'h0);
        check("rst_trace_data", trace_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].m2r, vecs[i].we, vecs[i].a3, vecs[i].ao, vecs[i].dr,
                  vecs[i].pc8, vecs[i].a1, vecs[i].a2);
            exp_q.push_back(vecs[i].exp_wd);
            #1;
            check($sformatf("v%0d_wd", i), WD, vecs[i].exp_wd);
            check($sformatf("v%0d_rd1", i), RD1, vecs[i].exp_rd1);
            check($sformatf("v%0d_rd2", i), RD2, vecs[i].exp_rd2);
            @(posedge clk);
            #1;
            check_trace($sformatf("v%0d", i), vecs[i].exp_commit, vecs[i].a3);
            @(negedge clk);
        end

        // async reset mid-run: reg8 holds 0x5678, reg31 holds 0x3008
        drive(2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd31);
        #1;
        check("pre_rst_rd1", RD1, 32'h5678);
        #2;
        reset = 1'b0;
        #1;
        check("async_rd1_cleared", RD1, 32'h0);
        check("async_rd2_cleared", RD2, 32'h0);
        check("async_trace_valid", {31'd0, trace_valid}, 32'h0);
        @(negedge clk);
        drive(2'd0, 1'b1, 5'd8, 32'h99, 32'h0, 32'h0, 5'd8, 5'd31);
        #1;
        check("rst_write_wd", WD, 32'h99);
        check("rst_write_no_bypass", RD1, 32'h0);
        @(posedge clk);
        #1;
        check("rst_write_dropped", RD1, 32'h0);
        check("rst_write_trace_valid", {31'd0, trace_valid}, 32'h0);
        @(negedge clk);
        drive(2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd31);
        reset = 1'b1;
        @(negedge clk);
        drive(2'd0, 1'b1, 5'd8, 32'h77, 32'h0, 32'h0, 5'd8, 5'd31);
        exp_q.push_back(32'h77);
        #1;
        check("post_rst_bypass", RD1, 32'h77);
        check("post_rst_rd2", RD2, 32'h0);
        @(posedge clk);
        #1;
        check_trace("post_rst", 1'b1, 5'd8);
        @(negedge clk);
        drive(2'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd0);
        #1;
        check("post_rst_read", RD1, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish within 100000 ns");
        $fatal(1);
    end

endmodule
